// File: rtl/bcd_digit_scanner.sv
// Time-multiplexed scanner for a 4-digit common-anode display; drives anN and the decoder's BCD input.
// Optional leading-zero blanking is compiled in when BCD_SCAN_LZB_EN is defined.
module bcd_digit_scanner #(
   parameter int REFRESH_DIV = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [15:0] value,
   input  logic [3:0]  digit_en,
   output logic [3:0]  BCD,
   output logic [3:0]  anN,
   output logic        upd_pending
);
   localparam int CNT_W = $clog2(REFRESH_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

   logic [CNT_W-1:0] prescaleCnt;
   logic [1:0]       digitIdx;
   logic [15:0]      shadowReg;
   logic [15:0]      activeReg;

   logic             step;
   logic             frameBoundary;
   logic [1:0]       nextIdx;
   logic [15:0]      activeNext;
   logic [3:0]       nibble [4];
   logic [3:0]       lzBlank;
   logic             slotOn;

   always_comb begin
      step          = (prescaleCnt == CNT_LAST);
      nextIdx       = digitIdx + 2'd1;
      frameBoundary = step && (digitIdx == 2'd3);
      // The new frame's digit 0 must already show the transferred value.
      activeNext    = (frameBoundary && upd_pending) ? shadowReg : activeReg;
      slotOn        = digit_en[nextIdx] && !lzBlank[nextIdx];
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_nibble
         assign nibble[gi] = activeNext[4*gi +: 4];
      end

`ifdef BCD_SCAN_LZB_EN
      assign lzBlank[0] = 1'b0;
      for (gi = 1; gi < 4; gi++) begin : g_lzb
         assign lzBlank[gi] = (activeNext[15:4*gi] == '0);
      end
`else
      assign lzBlank = 4'b0000;
`endif
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prescaleCnt <= '0;
         digitIdx    <= 2'd3;
         shadowReg   <= 16'h0000;
         activeReg   <= 16'h0000;
         upd_pending <= 1'b0;
         anN         <= 4'b1111;
         BCD         <= 4'hF;
      end else begin
         prescaleCnt <= step ? '0 : prescaleCnt + CNT_W'(1);
         activeReg   <= activeNext;

         if (load) begin
            shadowReg <= value;
         end
         // A load on the boundary edge keeps the flag set for the next frame.
         if (load) begin
            upd_pending <= 1'b1;
         end else if (frameBoundary) begin
            upd_pending <= 1'b0;
         end

         if (step) begin
            digitIdx <= nextIdx;
            if (slotOn) begin
               anN <= ~(4'b0001 << nextIdx);
               BCD <= nibble[nextIdx];
            end else begin
               anN <= 4'b1111;
               BCD <= 4'hF;
            end
         end
      end
   end
endmodule

// File: tb/tb_bcd_digit_scanner.sv
// Directed bench for bcd_digit_scanner at REFRESH_DIV=4; edge numbers count rising edges since reset release.
module tb_bcd_digit_scanner;
   logic        clk;
   logic        rst;
   logic        load;
   logic [15:0] value;
   logic [3:0]  digit_en;
   logic [3:0]  BCD;
   logic [3:0]  anN;
   logic        upd_pending;

   int nVec = 0;
   int nErr = 0;
   int e    = 0;

   typedef struct {
      logic [3:0] en;
      logic [3:0] an;
      logic [3:0] bcd;
      logic       pend;
   } vec_t;

   vec_t tbl [12];

   bcd_digit_scanner #(.REFRESH_DIV(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .load        (load),
      .value       (value),
      .digit_en    (digit_en),
      .BCD         (BCD),
      .anN         (anN),
      .upd_pending (upd_pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      e++;
   endtask

   task automatic runTo(input int target);
      while (e < target) tick();
   endtask

   task automatic doLoad(input logic [15:0] v);
      load  = 1'b1;
      value = v;
      tick();
      load  = 1'b0;
   endtask

   task automatic chk(input string nm, input logic [3:0] expAn, input logic [3:0] expBcd,
                      input logic expPend);
      nVec++;
      if (anN !== expAn || BCD !== expBcd || upd_pending !== expPend) begin
         nErr++;
         $display("FAIL %s @edge %0d: anN=%b BCD=%h pend=%b, expected anN=%b BCD=%h pend=%b",
                  nm, e, anN, BCD, upd_pending, expAn, expBcd, expPend);
      end else begin
         $display("ok   %s @edge %0d: anN=%b BCD=%h pend=%b", nm, e, anN, BCD, upd_pending);
      end
   endtask

   initial begin
      tbl[0]  = '{4'b1111, 4'b1101, 4'h0, 1'b1};
      tbl[1]  = '{4'b1111, 4'b1011, 4'h0, 1'b1};
      tbl[2]  = '{4'b1111, 4'b0111, 4'h0, 1'b1};
      tbl[3]  = '{4'b1111, 4'b1110, 4'h4, 1'b0};
      tbl[4]  = '{4'b1111, 4'b1101, 4'h3, 1'b0};
      tbl[5]  = '{4'b1111, 4'b1011, 4'h2, 1'b0};
      tbl[6]  = '{4'b1111, 4'b0111, 4'h1, 1'b0};
      tbl[7]  = '{4'b1111, 4'b1110, 4'h4, 1'b0};
      tbl[8]  = '{4'b0101, 4'b1111, 4'hF, 1'b0};
      tbl[9]  = '{4'b0101, 4'b1011, 4'h2, 1'b0};
      tbl[10] = '{4'b0101, 4'b1111, 4'hF, 1'b0};
      tbl[11] = '{4'b0101, 4'b1110, 4'h4, 1'b0};

      rst      = 1'b1;
      load     = 1'b0;
      value    = 16'h0000;
      digit_en = 4'b1111;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset held", 4'b1111, 4'hF, 1'b0);
      rst = 1'b0;
      e   = 0;
      chk("reset released", 4'b1111, 4'hF, 1'b0);

      runTo(3);
      chk("still dark edge3", 4'b1111, 4'hF, 1'b0);
      runTo(4);
      chk("first digit", 4'b1110, 4'h0, 1'b0);
      doLoad(16'h1234);
      chk("load 1234 pending", 4'b1110, 4'h0, 1'b1);
      runTo(7);

      // Each entry: one step edge followed by three hold cycles.
      for (int i = 0; i < 12; i++) begin
         digit_en = tbl[i].en;
         tick();
         chk($sformatf("slot%0d step", i), tbl[i].an, tbl[i].bcd, tbl[i].pend);
         for (int h = 0; h < 3; h++) begin
            tick();
            chk($sformatf("slot%0d hold%0d", i, h), tbl[i].an, tbl[i].bcd, tbl[i].pend);
         end
      end
      digit_en = 4'b1111;

      // Last load wins; 5678 must never reach the display.
      runTo(56);  chk("lw pre", 4'b1101, 4'h3, 1'b0);
      doLoad(16'h5678);
      chk("lw load1", 4'b1101, 4'h3, 1'b1);
      runTo(60);  chk("lw mid", 4'b1011, 4'h2, 1'b1);
      doLoad(16'h9ABC);
      runTo(67);  chk("lw before bnd", 4'b0111, 4'h1, 1'b1);
      runTo(68);  chk("lw d0", 4'b1110, 4'hC, 1'b0);
      runTo(72);  chk("lw d1", 4'b1101, 4'hB, 1'b0);
      runTo(76);  chk("lw d2", 4'b1011, 4'hA, 1'b0);
      runTo(80);  chk("lw d3", 4'b0111, 4'h9, 1'b0);

      // Load coincident with the boundary edge.
      doLoad(16'h1357);
      chk("bl load1", 4'b0111, 4'h9, 1'b1);
      runTo(83);
      doLoad(16'h2468);
      chk("bl d0 old shadow", 4'b1110, 4'h7, 1'b1);
      runTo(88);  chk("bl d1", 4'b1101, 4'h5, 1'b1);
      runTo(92);  chk("bl d2", 4'b1011, 4'h3, 1'b1);
      runTo(96);  chk("bl d3", 4'b0111, 4'h1, 1'b1);
      runTo(99);  chk("bl hold", 4'b0111, 4'h1, 1'b1);
      runTo(100); chk("bl new d0", 4'b1110, 4'h8, 1'b0);
      runTo(104); chk("bl new d1", 4'b1101, 4'h6, 1'b0);

      // Minimum latency, then leading-zero patterns.
      runTo(114);
      doLoad(16'h0042);
      chk("minlat pending", 4'b0111, 4'h2, 1'b1);
      runTo(116); chk("minlat d0", 4'b1110, 4'h2, 1'b0);
      runTo(120); chk("0042 d1", 4'b1101, 4'h4, 1'b0);
`ifdef BCD_SCAN_LZB_EN
      runTo(124); chk("0042 d2", 4'b1111, 4'hF, 1'b0);
      runTo(128); chk("0042 d3", 4'b1111, 4'hF, 1'b0);
`else
      runTo(124); chk("0042 d2", 4'b1011, 4'h0, 1'b0);
      runTo(128); chk("0042 d3", 4'b0111, 4'h0, 1'b0);
`endif
      doLoad(16'h0000);
      runTo(132); chk("0000 d0", 4'b1110, 4'h0, 1'b0);
`ifdef BCD_SCAN_LZB_EN
      runTo(136); chk("0000 d1", 4'b1111, 4'hF, 1'b0);
      runTo(140); chk("0000 d2", 4'b1111, 4'hF, 1'b0);
      runTo(144); chk("0000 d3", 4'b1111, 4'hF, 1'b0);
`else
      runTo(136); chk("0000 d1", 4'b1101, 4'h0, 1'b0);
      runTo(140); chk("0000 d2", 4'b1011, 4'h0, 1'b0);
      runTo(144); chk("0000 d3", 4'b0111, 4'h0, 1'b0);
`endif
      doLoad(16'h1004);
      runTo(148); chk("1004 d0", 4'b1110, 4'h4, 1'b0);
      runTo(152); chk("1004 d1", 4'b1101, 4'h0, 1'b0);
      runTo(156); chk("1004 d2", 4'b1011, 4'h0, 1'b0);
      runTo(160); chk("1004 d3", 4'b0111, 4'h1, 1'b0);

      // Asynchronous reset mid-frame discards pending and active data.
      runTo(161);
      doLoad(16'h7777);
      chk("pre-reset pending", 4'b0111, 4'h1, 1'b1);
      @(negedge clk);
      #1 rst = 1'b1;
      #1 chk("async reset", 4'b1111, 4'hF, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      e   = 0;
      runTo(3);   chk("re-reset dark", 4'b1111, 4'hF, 1'b0);
      runTo(4);   chk("re-reset d0", 4'b1110, 4'h0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end
endmodule
